seq_slice_adder_ctrl: RTL and testbench
=======================================

// Module: seq_slice_adder_ctrl
// PURPOSE
//   Multi-cycle sequencer for the block-adder datapath. Adds two DATA_WIDTH operands
//   by driving one BLOCK_SIZE-wide ripple slice, one slice per cycle, from LSB to MSB.
//   The carry is registered between slices. Operands enter and results leave through
//   valid/ready handshakes.
//   Used where area matters more than latency: an alternative to the single-cycle
//   carry-select adder on the same A/B/Cin -> S/Cout contract.
// PARAMETERS
//   DATA_WIDTH  32  operand and sum width in bits
//   BLOCK_SIZE  8   slice width added per cycle
//   CHUNKS = DATA_WIDTH/BLOCK_SIZE is a localparam.
//   DATA_WIDTH must be divisible by BLOCK_SIZE, and CHUNKS must be >= 2.
//   Elaboration fails otherwise.
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           synchronous, active-low reset
//   in_valid   in   1           A/B/Cin valid
//   in_ready   out  1           block can accept operands
//   A          in   DATA_WIDTH  operand A
//   B          in   DATA_WIDTH  operand B
//   Cin        in   1           carry into bit 0
//   out_valid  out  1           S/Cout hold a completed result
//   out_ready  in   1           consumer takes the result
//   S          out  DATA_WIDTH  sum
//   Cout       out  1           carry out of bit DATA_WIDTH-1
//   busy       out  1           operation in progress (state RUN)
// BEHAVIOUR
//   - FSM states and transitions:
//       IDLE -> RUN on in_valid & in_ready.
//       RUN -> DONE after slice CHUNKS-1.
//       DONE -> IDLE on out_ready.
//   - Reset (rst_n=0 at a clk edge):
//       state=IDLE, slice counter=0, carry reg=0, work reg=0.
//       S=0, Cout=0, out_valid=0, busy=0.
//       Any in-flight operation is dropped, whatever its state.
//       No handshake completes on a reset edge.
//   - in_ready = (state==IDLE), combinational from state.
//       in_ready is 0 in RUN and DONE, so A/B/Cin/in_valid are ignored there.
//   - Accept edge E0:
//       A, B and Cin are captured into internal operand regs, k=0, carry reg=Cin.
//       Later changes on A/B/Cin have no effect on this operation.
//   - RUN, edge Ek+1 (k = 0..CHUNKS-1):
//       {c,s} = A[k*BS+:BS] + B[k*BS+:BS] + carry, computed (BLOCK_SIZE+1) bits wide.
//       work[k*BS+:BS] <= s, carry <= c, k <= k+1.
//       On slice CHUNKS-1, state moves to DONE.
//   - Result load at edge E_CHUNKS:
//       S <= work with the final slice merged in, Cout <= final c, out_valid <= 1.
//       Latency is exactly CHUNKS cycles from the accept edge to out_valid=1.
//   - Outside the load edge, S and Cout hold their previous result; intermediate
//     slices are never visible on S.
//   - DONE:
//       S, Cout and out_valid stay stable until out_ready=1 at an edge.
//       That edge clears out_valid, and state moves to IDLE.
//       S and Cout keep their last value after the handshake.
//   - Throughput: in DONE, in_ready=0, so a new accept is possible no earlier than
//     the cycle after the output handshake.
//     Minimum spacing between accepts is CHUNKS+2 cycles.
//   - All sums are modulo 2^DATA_WIDTH, with the overflow carry reported on Cout.
//     Operands are treated as unsigned; there is no overflow flag.
// TESTING  (DATA_WIDTH=32, BLOCK_SIZE=8, CHUNKS=4 unless noted)
//   1. A=0x00000001, B=0x00000002, Cin=0
//      -> S=0x00000003, Cout=0, out_valid exactly 4 cycles after accept.
//   2. A=0xFFFFFFFF, B=0x00000000, Cin=1 -> S=0x00000000, Cout=1.
//      A=0x00FF00FF, B=0x00010001, Cin=0 -> S=0x01000100 (carry crosses slices).
//   3. out_ready=0 for 10 cycles after out_valid, with random A/B/in_valid driven
//      -> S, Cout and out_valid stable, in_ready=0.
//      Then out_ready=1 -> out_valid=0 the next cycle and in_ready=1.
//   4. rst_n=0 for one edge while k=2 in RUN
//      -> next cycle: out_valid=0, S=0, Cout=0, busy=0, in_ready=1.
//      The following op A=5, B=7 -> S=12.
//   5. Back-to-back ops with in_valid and out_ready held high
//      -> accepts spaced exactly 6 cycles apart; each result matches A+B+Cin.
//   6. 1000 random vectors with random valid/ready stalls, also at BLOCK_SIZE=16 and
//      BLOCK_SIZE=4 -> {Cout,S} == A+B+Cin every time, with no lost or duplicated
//      results.

Source files
------------

// File: rtl/seq_slice_adder_ctrl.sv
// seq_slice_adder_ctrl
//   This block adds two DATA_WIDTH-bit unsigned operands over several cycles.
//   It uses one BLOCK_SIZE-wide ripple slice and reuses it once per cycle,
//   working from the LSB slice up to the MSB slice. The carry is registered
//   between slices. It gives the same A/B/Cin -> S/Cout result as a
//   single-cycle adder, with less logic and more latency.
//
// Ports
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous, active-low reset
//   in_valid   in   1           A/B/Cin valid
//   in_ready   out  1           block can accept operands (state IDLE)
//   A, B       in   DATA_WIDTH  operands
//   Cin        in   1           carry into bit 0
//   out_valid  out  1           S/Cout hold a completed result
//   out_ready  in   1           consumer takes the result
//   S          out  DATA_WIDTH  sum (modulo 2^DATA_WIDTH)
//   Cout       out  1           carry out of bit DATA_WIDTH-1
//   busy       out  1           operation in progress (state RUN)
//
// Handshake rules (both ports)
//   A transfer happens at a rising edge where valid and ready are both 1 and
//   rst_n is 1. in_ready depends only on the state. out_valid is held, and so
//   are S/Cout, until a transfer happens.
//
// The FSM state can be decoded from in_ready (IDLE), busy (RUN) and
// out_valid (DONE). Exactly one of these three outputs is high at any time.

module seq_slice_adder_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_SIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  Cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] S,
   output logic                  Cout,
   output logic                  busy
);

   localparam int CHUNKS = DATA_WIDTH / BLOCK_SIZE;
   localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(CHUNKS - 1);

   if ((DATA_WIDTH % BLOCK_SIZE) != 0 || CHUNKS < 2) begin : g_param_check
      $error("seq_slice_adder_ctrl: DATA_WIDTH must be a multiple of BLOCK_SIZE with at least 2 slices");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      k_q, k_d;
   logic                  carry_q, carry_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] work_q, work_d;
   logic [DATA_WIDTH-1:0] s_q, s_d;
   logic                  cout_q, cout_d;
   logic                  ov_q, ov_d;

   // The operand regs shift right by one slice per cycle, so the active
   // slice is always in the low BLOCK_SIZE bits. Each new slice sum enters
   // the work reg from the top. After CHUNKS shifts, every slice has moved
   // down to its own position k*BLOCK_SIZE.
   logic [BLOCK_SIZE:0]   slice_sum;

   assign slice_sum = {1'b0, a_q[BLOCK_SIZE-1:0]}
                    + {1'b0, b_q[BLOCK_SIZE-1:0]}
                    + {{BLOCK_SIZE{1'b0}}, carry_q};

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign out_valid = ov_q;
   assign S         = s_q;
   assign Cout      = cout_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ov_d    = ov_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               k_d     = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> BLOCK_SIZE;
            b_d     = b_q >> BLOCK_SIZE;
            work_d  = {slice_sum[BLOCK_SIZE-1:0], work_q[DATA_WIDTH-1:BLOCK_SIZE]};
            carry_d = slice_sum[BLOCK_SIZE];
            k_d     = k_q + 1'b1;
            if (k_q == LAST_K) begin
               // Final slice: publish the merged word. Before this edge,
               // S keeps showing the previous result.
               s_d     = work_d;
               cout_d  = slice_sum[BLOCK_SIZE];
               ov_d    = 1'b1;
               k_d     = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ov_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ov_q    <= ov_d;
      end
   end

endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// tb_seq_slice_adder_ctrl
//   Bench for seq_slice_adder_ctrl. It uses three instances: BLOCK_SIZE 8,
//   16 and 4, all with DATA_WIDTH 32. The directed steps run on the
//   BLOCK_SIZE 8 instance. The random phase then runs on each instance in
//   turn. Inputs are driven and outputs are sampled on the falling edge.

module tb_seq_slice_adder_ctrl;

   localparam int DW = 32;

   // ---------------- clock / reset / signals ----------------
   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] a_in  = '0;
   logic [DW-1:0] b_in  = '0;
   logic          cin   = 1'b0;
   logic [2:0]    iv    = '0;
   logic [2:0]    ordy  = '0;
   wire  [2:0]    ir, ov, co, bz;
   wire  [DW-1:0] s0, s1, s2;

   always #5 clk = ~clk;

   seq_slice_adder_ctrl #(.DATA_WIDTH(DW), .BLOCK_SIZE(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .A(a_in), .B(b_in), .Cin(cin), .out_valid(ov[0]), .out_ready(ordy[0]),
      .S(s0), .Cout(co[0]), .busy(bz[0]));

   seq_slice_adder_ctrl #(.DATA_WIDTH(DW), .BLOCK_SIZE(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .A(a_in), .B(b_in), .Cin(cin), .out_valid(ov[1]), .out_ready(ordy[1]),
      .S(s1), .Cout(co[1]), .busy(bz[1]));

   seq_slice_adder_ctrl #(.DATA_WIDTH(DW), .BLOCK_SIZE(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .A(a_in), .B(b_in), .Cin(cin), .out_valid(ov[2]), .out_ready(ordy[2]),
      .S(s2), .Cout(co[2]), .busy(bz[2]));

   // ---------------- scoreboard ----------------
   int            checks   = 0;
   int            failures = 0;
   logic [DW:0]   exp_q[$];

   function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic c);
      return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
   endfunction

   function automatic logic [DW:0] result_of(input int idx);
      case (idx)
         0:       return {co[0], s0};
         1:       return {co[1], s1};
         default: return {co[2], s2};
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Pops the oldest expected result and compares it with the DUT output.
   task automatic compare_pop(input int idx, input string tag);
      logic [DW:0] e;
      check({tag, "_queue_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check(tag, 64'(result_of(idx)), 64'(e));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Presents operands and waits for the accept edge. Returns on the
   // falling edge that follows the accept edge.
   task automatic send(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic c);
      bit acc;
      acc  = 1'b0;
      a_in = a;
      b_in = b;
      cin  = c;
      iv[idx] = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (ir[idx]) begin
            acc = 1'b1;
            break;
         end
         tick();
      end
      check("send_accept", 64'(acc), 64'd1);
      if (acc) begin
         exp_q.push_back(model(a, b, c));
         tick();
      end
      iv[idx] = 1'b0;
   endtask

   // Counts cycles until out_valid goes high (bounded).
   task automatic wait_out(input int idx, output int lat);
      lat = 0;
      while (!ov[idx] && lat < 100) begin
         tick();
         lat++;
      end
      check("out_valid_seen", 64'(ov[idx]), 64'd1);
   endtask

   // Checks the result, completes the output handshake, then checks the
   // return to IDLE.
   task automatic take(input int idx, input string tag);
      compare_pop(idx, tag);
      ordy[idx] = 1'b1;
      tick();
      ordy[idx] = 1'b0;
      check({tag, "_ov_cleared"}, 64'(ov[idx]), 64'd0);
      check({tag, "_in_ready"}, 64'(ir[idx]), 64'd1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat;
      int cyc;
      int last;
      int nacc;
      bit acc;
      logic [DW:0] held;

      // reset
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_out_valid", 64'(ov[0]), 64'd0);
      check("rst_s", 64'(s0), 64'd0);
      check("rst_cout", 64'(co[0]), 64'd0);
      check("rst_busy", 64'(bz[0]), 64'd0);
      check("rst_in_ready", 64'(ir[0]), 64'd1);

      // 1: simple add and latency
      send(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
      check("t1_busy", 64'(bz[0]), 64'd1);
      check("t1_in_ready_low", 64'(ir[0]), 64'd0);
      tick();
      check("t1_s_hidden", 64'(s0), 64'd0);
      wait_out(0, lat);
      check("t1_latency", 64'(lat + 1), 64'd4);
      take(0, "t1_result");

      // 2: carry ripple through all slices and across slice boundaries
      send(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_out(0, lat);
      take(0, "t2a_result");
      send(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0);
      wait_out(0, lat);
      take(0, "t2b_result");

      // 3: output stall with noise on the input side
      send(0, 32'h89AB_CDEF, 32'h7654_3211, 1'b1);
      wait_out(0, lat);
      held = (exp_q.size() != 0) ? exp_q[0] : '0;
      for (int i = 0; i < 10; i++) begin
         a_in  = $urandom;
         b_in  = $urandom;
         cin   = 1'($urandom_range(0, 1));
         iv[0] = 1'($urandom_range(0, 1));
         check("t3_ov_stable", 64'(ov[0]), 64'd1);
         check("t3_result_stable", 64'(result_of(0)), 64'(held));
         check("t3_in_ready_low", 64'(ir[0]), 64'd0);
         tick();
      end
      iv[0] = 1'b0;
      take(0, "t3_result");

      // 4: reset while the slice counter is at 2
      send(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      check("t4_out_valid", 64'(ov[0]), 64'd0);
      check("t4_s", 64'(s0), 64'd0);
      check("t4_cout", 64'(co[0]), 64'd0);
      check("t4_busy", 64'(bz[0]), 64'd0);
      check("t4_in_ready", 64'(ir[0]), 64'd1);
      send(0, 32'd5, 32'd7, 1'b0);
      wait_out(0, lat);
      take(0, "t4_result");

      // 5: back-to-back with in_valid and out_ready held high
      a_in    = $urandom;
      b_in    = $urandom;
      cin     = 1'($urandom_range(0, 1));
      iv[0]   = 1'b1;
      ordy[0] = 1'b1;
      cyc  = 0;
      last = -1;
      nacc = 0;
      for (int t = 0; t < 80 && nacc < 5; t++) begin
         acc = 1'b0;
         if (ov[0]) compare_pop(0, "t5_result");
         if (ir[0]) begin
            exp_q.push_back(model(a_in, b_in, cin));
            if (last >= 0) check("t5_spacing", 64'(cyc - last), 64'd6);
            last = cyc;
            nacc++;
            acc  = 1'b1;
         end
         tick();
         cyc++;
         if (acc) begin
            a_in = $urandom;
            b_in = $urandom;
            cin  = 1'($urandom_range(0, 1));
         end
      end
      iv[0] = 1'b0;
      check("t5_accepts", 64'(nacc), 64'd5);
      wait_out(0, lat);
      take(0, "t5_last_result");

      // 6: random traffic with stalls on each slice width
      for (int idx = 0; idx < 3; idx++) begin
         int sent;
         int got;
         sent = 0;
         got  = 0;
         exp_q.delete();
         for (int t = 0; t < 40000 && got < 1000; t++) begin
            if (ov[idx] && ordy[idx]) begin
               compare_pop(idx, $sformatf("t6_result_dut%0d", idx));
               got++;
            end
            if (iv[idx] && ir[idx]) begin
               exp_q.push_back(model(a_in, b_in, cin));
               sent++;
            end
            tick();
            a_in      = $urandom;
            b_in      = $urandom;
            cin       = 1'($urandom_range(0, 1));
            iv[idx]   = (sent < 1000) && ($urandom_range(0, 1) == 1);
            ordy[idx] = ($urandom_range(0, 2) != 0);
         end
         iv[idx]   = 1'b0;
         ordy[idx] = 1'b0;
         check($sformatf("t6_count_dut%0d", idx), 64'(got), 64'd1000);
         check($sformatf("t6_sent_dut%0d", idx), 64'(sent), 64'd1000);
         check($sformatf("t6_queue_empty_dut%0d", idx), 64'(exp_q.size()), 64'd0);
         tick();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
